uncache_axi_bridge: RTL and testbench

UNCACHE_AXI_BRIDGE -- requirements
Module: uncache_axi_bridge

---
 rtl/uncache_axi_bridge.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uncache_axi_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_axi_bridge.sv
// Uncached single-beat AXI4 master bridge.
// Turns a held rd_req/wr_req level request into one AXI4 read or write
// transaction and reports completion with a one-cycle reload pulse.
// Optional build macro: UNCACHE_BRIDGE_ERR_EN. When it is defined, non-OKAY
// responses are recorded in a sticky bus_err flag and in err_addr.
module uncache_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  // request side
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic        wr_req,
  input  logic [3:0]  wr_wstrb,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        reload,
  output logic [31:0] rd_data,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // error reporting
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    RD_A  = 6'b000010,
    RD_D  = 6'b000100,
    WR_AW = 6'b001000,
    WR_B  = 6'b010000,
    DONE  = 6'b100000
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        reload_q, reload_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic aw_hs, w_hs, rd_fin, wr_fin;

  // Channel handshakes and the two completing handshakes of a transaction
  assign aw_hs  = awvalid_q & awready;
  assign w_hs   = wvalid_q & wready;
  assign rd_fin = (state_q == RD_D) & rvalid & rready_q;
  assign wr_fin = (state_q == WR_B) & bvalid & bready_q;

  // Single-beat, 32-bit, unprivileged, non-cacheable sideband
  assign arid    = 4'd0;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd0;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;

  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign reload  = reload_q;
  assign rd_data = rd_data_q;

  // Every transaction is a single beat, so rlast carries no information
  logic unused_rlast;
  assign unused_rlast = rlast;

  // Next-state and registered-output logic of the transaction FSM
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    reload_d  = 1'b0;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          araddr_d  = rd_addr;
          arvalid_d = 1'b1;
          state_d   = RD_A;
        end else if (wr_req) begin
          awaddr_d  = wr_addr;
          wdata_d   = wr_data;
          wstrb_d   = wr_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_AW;
        end
      end
      RD_A: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (rd_fin) begin
          rd_data_d = rdata;
          rready_d  = 1'b0;
          reload_d  = 1'b1;
          state_d   = DONE;
        end
      end
      WR_AW: begin
        // AW and W retire independently; either order or the same cycle
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        if (wr_fin) begin
          bready_d = 1'b0;
          reload_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Requests are not looked at here, so a still-held request is not reissued
        state_d = IDLE;
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      reload_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      reload_q  <= reload_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef UNCACHE_BRIDGE_ERR_EN
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;

  // Sticky error flag; only the first failing access records its address
  always_comb begin
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (rd_fin && (rresp != 2'b00)) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) err_addr_d = araddr_q;
    end
    if (wr_fin && (bresp != 2'b00)) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) err_addr_d = awaddr_q;
    end
  end

  // Error registers, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  // Responses are not inspected in this build
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign bus_err     = 1'b0;
  assign err_addr    = 32'd0;
`endif

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Directed self-checking bench for uncache_axi_bridge.
// Expected rd_data values are queued when a request is driven and popped
// on each reload pulse. Error-capture expectations follow UNCACHE_BRIDGE_ERR_EN.
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_wstrb;
  logic        reload;
  logic [31:0] rd_data;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst;
  logic        arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;
  logic        bus_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int ar0, aw0, w0;
  logic [31:0] exp_q[$];
  logic        exp_be;
  logic [31:0] exp_ea;

  always #5 clk = ~clk;

  uncache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .wr_req(wr_req), .wr_wstrb(wr_wstrb),
    .wr_addr(wr_addr), .wr_data(wr_data), .reload(reload), .rd_data(rd_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  // Handshake counters
  always @(posedge clk) begin
    if (arvalid && arready) ar_cnt++;
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready)   w_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_reload(input string tag);
    chk({tag, "_reload"}, {31'd0, reload}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard: observed empty queue, expected a queued result", tag);
    end else begin
      chk({tag, "_rd_data"}, rd_data, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; wr_wstrb = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid",  {31'd0, wvalid},  32'd0);
    chk("rst_rready",  {31'd0, rready},  32'd0);
    chk("rst_bready",  {31'd0, bready},  32'd0);
    chk("rst_reload",  {31'd0, reload},  32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_araddr",  araddr,  32'd0);
    chk("rst_awaddr",  awaddr,  32'd0);
    chk("rst_wdata",   wdata,   32'd0);
    chk("rst_wstrb",   {28'd0, wstrb}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("const_arsize", {29'd0, arsize}, 32'd2);
    chk("const_awburst", {30'd0, awburst}, 32'd1);
    chk("const_wlast", {31'd0, wlast}, 32'd1);
    chk("const_arlen", {24'd0, arlen}, 32'd0);
    rst = 1'b0;
    tick;

    // Zero-wait read
    rd_req = 1; rd_addr = 32'h1FAF_F000; arready = 1;
    exp_q.push_back(32'h1234_5678);
    ar0 = ar_cnt;
    tick;
    chk("rd_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rd_araddr", araddr, 32'h1FAF_F000);
    tick;
    chk("rd_arvalid_drop", {31'd0, arvalid}, 32'd0);
    chk("rd_rready", {31'd0, rready}, 32'd1);
    chk("rd_no_early_reload", {31'd0, reload}, 32'd0);
    rvalid = 1; rdata = 32'h1234_5678;
    tick;
    expect_reload("rd");
    rvalid = 0; rdata = 0; rd_req = 0; arready = 0;
    tick;
    chk("rd_reload_one_cycle", {31'd0, reload}, 32'd0);
    chk("rd_ar_count", ar_cnt - ar0, 32'd1);

    // Write: W before AW, late B
    wr_req = 1; wr_addr = 32'hBFD0_03F8; wr_data = 32'h0000_00A5; wr_wstrb = 4'b0001;
    exp_q.push_back(32'h1234_5678);
    aw0 = aw_cnt; w0 = w_cnt;
    tick;
    chk("wr_awvalid", {31'd0, awvalid}, 32'd1);
    chk("wr_wvalid", {31'd0, wvalid}, 32'd1);
    chk("wr_awaddr", awaddr, 32'hBFD0_03F8);
    chk("wr_wdata", wdata, 32'h0000_00A5);
    chk("wr_wstrb", {28'd0, wstrb}, 32'd1);
    wready = 1;
    tick;
    chk("wr_wvalid_drop", {31'd0, wvalid}, 32'd0);
    chk("wr_awvalid_hold", {31'd0, awvalid}, 32'd1);
    chk("wr_awaddr_stable", awaddr, 32'hBFD0_03F8);
    wready = 0; awready = 1;
    tick;
    chk("wr_awvalid_drop", {31'd0, awvalid}, 32'd0);
    chk("wr_bready", {31'd0, bready}, 32'd1);
    awready = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wr_wait_b_no_reload", {31'd0, reload}, 32'd0);
    end
    bvalid = 1;
    tick;
    expect_reload("wr");
    chk("wr_bready_drop", {31'd0, bready}, 32'd0);
    bvalid = 0; wr_req = 0;
    tick;
    chk("wr_reload_one_cycle", {31'd0, reload}, 32'd0);
    chk("wr_aw_count", aw_cnt - aw0, 32'd1);
    chk("wr_w_count", w_cnt - w0, 32'd1);

    // Back-to-back: read held past reload, then a write
    rd_req = 1; rd_addr = 32'h0000_1000; arready = 1;
    exp_q.push_back(32'hCAFE_F00D);
    ar0 = ar_cnt;
    tick;
    tick;
    rvalid = 1; rdata = 32'hCAFE_F00D;
    tick;
    expect_reload("b2b_rd");
    rvalid = 0;
    tick;
    chk("b2b_no_second_ar", {31'd0, arvalid}, 32'd0);
    rd_req = 0;
    wr_req = 1; wr_addr = 32'h0000_2000; wr_data = 32'h0000_5A5A; wr_wstrb = 4'hF;
    awready = 1; wready = 1;
    exp_q.push_back(32'hCAFE_F00D);
    tick;
    chk("b2b_wr_awvalid", {31'd0, awvalid}, 32'd1);
    tick;
    chk("b2b_wr_bready", {31'd0, bready}, 32'd1);
    awready = 0; wready = 0; bvalid = 1;
    tick;
    expect_reload("b2b_wr");
    bvalid = 0; wr_req = 0; arready = 0;
    tick;
    chk("b2b_ar_count", ar_cnt - ar0, 32'd1);

    // Both requests high: read first, write afterwards
    rd_req = 1; rd_addr = 32'h0000_3000; wr_req = 1; wr_addr = 32'h0000_4000;
    wr_data = 32'h0000_0011; wr_wstrb = 4'b0011; arready = 1;
    exp_q.push_back(32'h0BAD_BEEF);
    exp_q.push_back(32'h0BAD_BEEF);
    tick;
    chk("both_arvalid", {31'd0, arvalid}, 32'd1);
    chk("both_no_awvalid", {31'd0, awvalid}, 32'd0);
    tick;
    rvalid = 1; rdata = 32'h0BAD_BEEF;
    tick;
    expect_reload("both_rd");
    chk("both_no_awvalid_done", {31'd0, awvalid}, 32'd0);
    rvalid = 0; rd_req = 0; arready = 0;
    tick;
    chk("both_no_awvalid_idle", {31'd0, awvalid}, 32'd0);
    tick;
    chk("both_awvalid", {31'd0, awvalid}, 32'd1);
    chk("both_awaddr", awaddr, 32'h0000_4000);
    awready = 1;
    tick;
    chk("both_aw_first_drop", {31'd0, awvalid}, 32'd0);
    chk("both_w_still", {31'd0, wvalid}, 32'd1);
    awready = 0; wready = 1;
    tick;
    chk("both_w_drop", {31'd0, wvalid}, 32'd0);
    chk("both_bready", {31'd0, bready}, 32'd1);
    wready = 0; bvalid = 1;
    tick;
    expect_reload("both_wr");
    bvalid = 0; wr_req = 0;
    tick;
    chk("both_reload_one_cycle", {31'd0, reload}, 32'd0);

    // Reset during RD_D with rvalid pending
    rd_req = 1; rd_addr = 32'h0000_5000; arready = 1;
    tick;
    tick;
    chk("rstmid_rready", {31'd0, rready}, 32'd1);
    rvalid = 1; rdata = 32'h0000_DEAD;
    #2;
    rst = 1;
    #1;
    chk("rstmid_rready_clr", {31'd0, rready}, 32'd0);
    chk("rstmid_reload", {31'd0, reload}, 32'd0);
    chk("rstmid_rd_data", rd_data, 32'd0);
    chk("rstmid_araddr", araddr, 32'd0);
    chk("rstmid_awaddr", awaddr, 32'd0);
    rd_req = 0; rvalid = 0; arready = 0; rdata = 0;
    tick;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rstmid_no_reload", {31'd0, reload}, 32'd0);
    end

    // Error response capture
`ifdef UNCACHE_BRIDGE_ERR_EN
    exp_be = 1'b1;
    exp_ea = 32'h8000_0010;
`else
    exp_be = 1'b0;
    exp_ea = 32'h0000_0000;
`endif
    wr_req = 1; wr_addr = 32'h8000_0010; wr_data = 32'h0000_0001; wr_wstrb = 4'hF;
    awready = 1; wready = 1; bresp = 2'b10;
    exp_q.push_back(32'h0000_0000);
    tick;
    tick;
    bvalid = 1;
    tick;
    expect_reload("err_wr");
    bvalid = 0; bresp = 0; wr_req = 0; awready = 0; wready = 0;
    tick;
    chk("err_wr_bus_err", {31'd0, bus_err}, {31'd0, exp_be});
    chk("err_wr_err_addr", err_addr, exp_ea);
    rd_req = 1; rd_addr = 32'h9000_0000; arready = 1;
    exp_q.push_back(32'h0000_0077);
    tick;
    tick;
    rvalid = 1; rdata = 32'h0000_0077; rresp = 2'b10;
    tick;
    expect_reload("err_rd");
    rvalid = 0; rresp = 0; rd_req = 0; arready = 0;
    tick;
    chk("err_rd_bus_err", {31'd0, bus_err}, {31'd0, exp_be});
    chk("err_rd_err_addr_kept", err_addr, exp_ea);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
